// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields back into a 32-bit RV64I word.
// A one-entry output register with valid/ready on both sides; the LI pseudo-op
// (load a 32-bit constant) expands into LUI followed by ADDIW over two beats.
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not fit
// the selected format on o_imm_err (otherwise o_imm_err is tied low).
module instr_encoder #(
  parameter int TYPE_W = 3,
  parameter int XLEN   = 32
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [TYPE_W-1:0] i_imm_type,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [XLEN-1:0]   i_imm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic              o_last,
  output logic              o_illegal,
  output logic              o_imm_err
);

  localparam logic [TYPE_W-1:0] TYPE_I  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TYPE_S  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_B  = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] TYPE_J  = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] TYPE_U  = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] TYPE_R  = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] TYPE_LI = TYPE_W'(6);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_ADDIW = 7'b0011011;

  typedef enum logic {
    IDLE,
    SECOND
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo12_q, lo12_d;

  logic [31:0] imm32;
  logic [31:0] liSum;
  logic [31:0] wordEnc;
  logic        isLi;
  logic        isIllegal;
  logic        accept;
  logic        drain;

  assign imm32     = i_imm[31:0];
  // Rounding by 0x800 compensates for ADDIW sign-extending its 12-bit immediate;
  // the sum deliberately wraps modulo 2^32.
  assign liSum     = imm32 + 32'h800;
  assign isLi      = (i_imm_type == TYPE_LI);
  assign isIllegal = (i_imm_type == TYPE_W'(7));

  assign o_ready = (state_q == IDLE) & (!valid_q | i_ready);
  assign accept  = i_valid & o_ready;
  assign drain   = valid_q & i_ready;

  assign o_valid   = valid_q;
  assign o_instr   = instr_q;
  assign o_last    = last_q;
  assign o_illegal = illegal_q;

  // Scatter the immediate into the bit positions of the selected single-beat format.
  always_comb begin
    wordEnc = 32'h0;
    case (i_imm_type)
      TYPE_I: wordEnc = {imm32[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      TYPE_S: wordEnc = {imm32[11:5], i_rs2, i_rs1, i_funct3, imm32[4:0], i_opcode};
      TYPE_B: wordEnc = {imm32[12], imm32[10:5], i_rs2, i_rs1, i_funct3,
                         imm32[4:1], imm32[11], i_opcode};
      TYPE_J: wordEnc = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], i_rd, i_opcode};
      TYPE_U: wordEnc = {imm32[31:12], i_rd, i_opcode};
      TYPE_R: wordEnc = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      default: wordEnc = 32'h0;
    endcase
  end

  // Output register and LI sequencing: load on accept, emit ADDIW when LUI drains.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    last_d    = last_q;
    illegal_d = illegal_q;
    rd_d      = rd_q;
    lo12_d    = lo12_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          if (isLi) begin
            instr_d   = {liSum[31:12], i_rd, OPC_LUI};
            last_d    = 1'b0;
            illegal_d = 1'b0;
            rd_d      = i_rd;
            lo12_d    = imm32[11:0];
            state_d   = SECOND;
          end else begin
            instr_d   = wordEnc;
            last_d    = 1'b1;
            illegal_d = isIllegal;
          end
        end else if (drain) begin
          valid_d = 1'b0;
        end
      end
      SECOND: begin
        if (drain) begin
          valid_d   = 1'b1;
          instr_d   = {lo12_q, rd_q, 3'b000, rd_q, OPC_ADDIW};
          last_d    = 1'b1;
          illegal_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register update with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_arstn) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= 5'd0;
      lo12_q    <= 12'h0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
      rd_q      <= rd_d;
      lo12_q    <= lo12_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] immS;
  logic               immErrCalc;
  logic               immErr_q;

  assign immS      = $signed(imm32);
  assign o_imm_err = immErr_q;

  // Flag immediates that the chosen format cannot represent exactly.
  always_comb begin
    immErrCalc = 1'b0;
    case (i_imm_type)
      TYPE_I, TYPE_S: immErrCalc = (immS < -32'sd2048) || (immS > 32'sd2047);
      TYPE_B: immErrCalc = (immS < -32'sd4096) || (immS > 32'sd4094) || imm32[0];
      TYPE_J: immErrCalc = (immS < -32'sd1048576) || (immS > 32'sd1048574) || imm32[0];
      TYPE_U: immErrCalc = (imm32[11:0] != 12'h0);
      default: immErrCalc = 1'b0;
    endcase
  end

  // The error flag travels with its word; the ADDIW beat and idle slots carry 0.
  always_ff @(posedge i_clk) begin
    if (!i_arstn) begin
      immErr_q <= 1'b0;
    end else if (accept) begin
      immErr_q <= immErrCalc;
    end else if (drain) begin
      immErr_q <= 1'b0;
    end
  end
`else
  assign o_imm_err = 1'b0;
`endif

endmodule
